// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer that owns HI/LO and raises the
// decode stall while a result is pending.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  input  logic             MfhiD,
  input  logic             MfloD,
  input  logic             MulDivD,
  input  logic             MthiW,
  input  logic             MtloW,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             BusyMD,
  output logic             DoneMD,
  output logic             StallMD
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           stateQ, stateD;
  logic [CntW-1:0]  countQ, countD;
  logic [WIDTH-1:0] accHiQ, accHiD, accLoQ, accLoD, divisorQ, divisorD;
  logic [WIDTH-1:0] hiQ, hiD, loQ, loD;
  logic             isDivQ, isDivD, negResQ, negResD, negRemQ, negRemD;
  logic             divZeroQ, divZeroD;

  // Operand magnitudes; unsigned ops (OpE[0]=1) pass values through untouched.
  logic             negA, negB;
  logic [WIDTH-1:0] magA, magB;
  assign negA = ~OpE[0] & SrcAE[WIDTH-1];
  assign negB = ~OpE[0] & SrcBE[WIDTH-1];
  assign magA = negA ? -SrcAE : SrcAE;
  assign magB = negB ? -SrcBE : SrcBE;

  // One iteration of each algorithm; accLo holds multiplier / dividend-quotient.
  logic [WIDTH:0]     mulSum, divShift;
  logic [WIDTH-1:0]   divDiff;
  logic               divGe;
  logic [2*WIDTH-1:0] prod;
  assign mulSum   = {1'b0, accHiQ} + (accLoQ[0] ? {1'b0, divisorQ} : '0);
  assign divShift = {accHiQ, accLoQ[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, divisorQ};
  // Partial remainder is always below 2*divisor, so the difference fits WIDTH bits.
  assign divDiff  = divShift[WIDTH-1:0] - divisorQ;
  assign prod     = {accHiQ, accLoQ};

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    accHiD   = accHiQ;
    accLoD   = accLoQ;
    divisorD = divisorQ;
    isDivD   = isDivQ;
    negResD  = negResQ;
    negRemD  = negRemQ;
    divZeroD = divZeroQ;
    hiD      = hiQ;
    loD      = loQ;
    case (stateQ)
      StIdle: begin
        if (MthiW) hiD = ResultW;
        if (MtloW) loD = ResultW;
        if (StartE && !FlushE) begin
          stateD   = StBusy;
          countD   = '0;
          accHiD   = '0;
          accLoD   = magA;
          divisorD = magB;
          isDivD   = OpE[1];
          negResD  = negA ^ negB;
          negRemD  = negA;
          divZeroD = (SrcBE == '0);
        end
      end
      StBusy: begin
        countD = countQ + CntW'(1);
        if (isDivQ) begin
          accHiD = divGe ? divDiff : divShift[WIDTH-1:0];
          accLoD = {accLoQ[WIDTH-2:0], divGe};
        end else begin
          {accHiD, accLoD} = {mulSum, accLoQ[WIDTH-1:1]};
        end
        if (countQ == LastCnt) stateD = StDone;
      end
      StDone: begin
        stateD = StIdle;
        if (isDivQ) begin
          // A zero divisor leaves the dividend magnitude in accHi; re-signing restores it.
          hiD = negRemQ ? -accHiQ : accHiQ;
          loD = divZeroQ ? '1 : (negResQ ? -accLoQ : accLoQ);
        end else begin
          {hiD, loD} = negResQ ? -prod : prod;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      countQ   <= '0;
      accHiQ   <= '0;
      accLoQ   <= '0;
      divisorQ <= '0;
      isDivQ   <= 1'b0;
      negResQ  <= 1'b0;
      negRemQ  <= 1'b0;
      divZeroQ <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      stateQ   <= stateD;
      countQ   <= countD;
      accHiQ   <= accHiD;
      accLoQ   <= accLoD;
      divisorQ <= divisorD;
      isDivQ   <= isDivD;
      negResQ  <= negResD;
      negRemQ  <= negRemD;
      divZeroQ <= divZeroD;
      hiQ      <= hiD;
      loQ      <= loD;
    end
  end

  assign Hi      = hiQ;
  assign Lo      = loQ;
  assign BusyMD  = (stateQ != StIdle);
  assign DoneMD  = (stateQ == StDone);
  assign StallMD = BusyMD && (MfhiD || MfloD || MulDivD);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic
// reference model of HI/LO results and cycle timing.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE, FlushE, MfhiD, MfloD, MulDivD, MthiW, MtloW;
  logic [1:0]  OpE;
  logic [31:0] SrcAE, SrcBE, ResultW, Hi, Lo;
  logic        BusyMD, DoneMD, StallMD;

  int nVec = 0;
  int nBad = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .FlushE(FlushE), .MfhiD(MfhiD), .MfloD(MfloD), .MulDivD(MulDivD), .MthiW(MthiW),
    .MtloW(MtloW), .ResultW(ResultW), .Hi(Hi), .Lo(Lo), .BusyMD(BusyMD),
    .DoneMD(DoneMD), .StallMD(StallMD)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randDecode();
    MfhiD   = 1'($urandom_range(0, 1));
    MfloD   = 1'($urandom_range(0, 1));
    MulDivD = 1'($urandom_range(0, 1));
  endtask

  task automatic clearInputs();
    StartE = 0; FlushE = 0; MfhiD = 0; MfloD = 0; MulDivD = 0; MthiW = 0; MtloW = 0;
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mtSameEdge);
    logic [63:0] res;
    int doneCnt;
    res = refModel(op, a, b);
    StartE = 1; OpE = op; SrcAE = a; SrcBE = b; FlushE = 0;
    if (mtSameEdge) begin
      MthiW = 1;
      ResultW = $urandom;
      expHi = ResultW;
    end
    tick();
    StartE = 0; MthiW = 0;
    if (mtSameEdge) checkVal("mthiOnAccept", 64'(Hi), 64'(expHi));
    doneCnt = 0;
    for (int j = 0; j <= 32; j++) begin
      randDecode();
      MthiW = 1'($urandom_range(0, 1));
      MtloW = 1'($urandom_range(0, 1));
      ResultW = $urandom;
      #1;
      checkVal("busy", 64'(BusyMD), 64'(1));
      checkVal("done", 64'(DoneMD), 64'(j == 32));
      checkVal("stall", 64'(StallMD), 64'(MfhiD | MfloD | MulDivD));
      checkVal("hiHeld", 64'(Hi), 64'(expHi));
      checkVal("loHeld", 64'(Lo), 64'(expLo));
      if (DoneMD) doneCnt++;
      tick();
    end
    MthiW = 0; MtloW = 0;
    randDecode();
    #1;
    checkVal("doneCount", 64'(doneCnt), 64'(1));
    checkVal("idleBusy", 64'(BusyMD), 64'(0));
    checkVal("idleStall", 64'(StallMD), 64'(0));
    checkVal("hi", 64'(Hi), 64'(res[63:32]));
    checkVal("lo", 64'(Lo), 64'(res[31:0]));
    expHi = res[63:32];
    expLo = res[31:0];
    clearInputs();
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, v;
    int doneSeen;
    clearInputs();
    OpE = 0; SrcAE = 0; SrcBE = 0; ResultW = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    MfloD = 1;
    #1;
    checkVal("rstHi", 64'(Hi), 64'(0));
    checkVal("rstLo", 64'(Lo), 64'(0));
    checkVal("rstBusy", 64'(BusyMD), 64'(0));
    checkVal("rstDone", 64'(DoneMD), 64'(0));
    checkVal("rstStall", 64'(StallMD), 64'(0));
    MfloD = 0;

    runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkVal("multuMaxHi", 64'(Hi), 64'(32'hFFFF_FFFE));
    runOp(2'd0, -32'sd7, 32'd3, 1'b0);
    checkVal("multNegLo", 64'(Lo), 64'(32'hFFFF_FFEB));
    runOp(2'd2, -32'sd7, 32'd2, 1'b0);
    checkVal("divNegLo", 64'(Lo), 64'(32'hFFFF_FFFD));
    runOp(2'd3, 32'd100, 32'd0, 1'b0);
    checkVal("divuZeroHi", 64'(Hi), 64'(100));
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkVal("divOvfLo", 64'(Lo), 64'(32'h8000_0000));
    runOp(2'd2, -32'sd9, 32'd0, 1'b0);
    runOp(2'd0, 32'd5, 32'd6, 1'b1);

    // Flushed start must not begin an operation.
    StartE = 1; FlushE = 1; OpE = 2'd1; SrcAE = 32'd3; SrcBE = 32'd4;
    tick();
    clearInputs();
    checkVal("flushBusy", 64'(BusyMD), 64'(0));
    checkVal("flushHi", 64'(Hi), 64'(expHi));
    checkVal("flushLo", 64'(Lo), 64'(expLo));

    v = $urandom;
    MthiW = 1; MtloW = 1; ResultW = v;
    tick();
    clearInputs();
    expHi = v; expLo = v;
    checkVal("mtBothHi", 64'(Hi), 64'(v));
    checkVal("mtBothLo", 64'(Lo), 64'(v));

    // Reset ten cycles into a divide discards the result.
    StartE = 1; OpE = 2'd2; SrcAE = 32'd1000; SrcBE = 32'd7;
    tick();
    StartE = 0;
    for (int j = 0; j < 10; j++) tick();
    rst = 1;
    tick();
    rst = 0;
    expHi = '0; expLo = '0;
    checkVal("midRstBusy", 64'(BusyMD), 64'(0));
    checkVal("midRstHi", 64'(Hi), 64'(0));
    checkVal("midRstLo", 64'(Lo), 64'(0));
    doneSeen = 0;
    for (int j = 0; j < 30; j++) begin
      if (DoneMD || BusyMD) doneSeen++;
      tick();
    end
    checkVal("midRstNoDone", 64'(doneSeen), 64'(0));

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      runOp(op, a, b, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
